// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback/scoreboard slice.
package wb_pkg;
  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 32;
  localparam logic [WB_ADDR_WIDTH-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic                     wen;
    logic [WB_ADDR_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_EXU, SRC_LSU} src_sel_t;
endpackage

// File: rtl/wb_busy_table.sv
// wb_busy_table: per-register pending-write bits; set beats clear, entry 0 is never busy.
module wb_busy_table #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [ADDR_WIDTH-1:0] iss_addr,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  iss_busy,
  output logic                  wb_busy
);
  localparam int NREG = 2**ADDR_WIDTH;
  logic [NREG-1:0] busy_q, busy_d;
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clock) busy_q <= reset ? '0 : busy_d;
  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];
  assign iss_busy = busy_q[iss_addr];
  assign wb_busy  = busy_q[wb_addr];
endmodule

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: LSU-priority writeback arbiter with registered rf write port and RAW/WAW busy table.
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic                  issue_wen,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic                  exu_wen,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic                  lsu_wen,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [31:0]           retire_cnt,
  output logic                  err_unexp_wb
);
  src_sel_t              sel;
  logic                  pick_wen, fire, wr, iss_busy, wb_busy, issue_fire;
  logic [ADDR_WIDTH-1:0] pick_rd, rf_waddr_q;
  logic [DATA_WIDTH-1:0] pick_data, rf_wdata_q;
  logic                  rf_wen_q, err_q;
  logic [31:0]           cnt_q;
  always_comb begin
    sel       = reset ? SRC_NONE : lsu_valid ? SRC_LSU : exu_valid ? SRC_EXU : SRC_NONE;
    pick_wen  = sel == SRC_LSU ? lsu_wen  : exu_wen;
    pick_rd   = sel == SRC_LSU ? lsu_rd   : exu_rd;
    pick_data = sel == SRC_LSU ? lsu_data : exu_data;
  end
  assign fire        = sel != SRC_NONE;
  assign wr          = fire && pick_wen && |pick_rd;
  assign lsu_ready   = !reset;
  assign exu_ready   = !reset && !lsu_valid;
  // A busy destination may still issue when its old write retires on this edge.
  assign issue_ready = !reset && (!issue_wen || ~|issue_rd || !iss_busy
                       || (rf_wen_q && rf_waddr_q == issue_rd));
  assign issue_fire  = issue_valid && issue_ready && issue_wen && |issue_rd;
  wb_busy_table #(.ADDR_WIDTH(ADDR_WIDTH)) u_busy (
    .clock    (clock),
    .reset    (reset),
    .set_en   (issue_fire),
    .set_addr (issue_rd),
    .clr_en   (rf_wen_q),
    .clr_addr (rf_waddr_q),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .iss_addr (issue_rd),
    .wb_addr  (pick_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .iss_busy (iss_busy),
    .wb_busy  (wb_busy)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      rf_wen_q <= wr;
      if (fire) begin
        rf_waddr_q <= pick_rd;
        rf_wdata_q <= pick_data;
        cnt_q      <= cnt_q + 32'd1;
      end
      if (wr && !wb_busy) err_q <= 1'b1;
    end
  end
  assign rf_wen       = rf_wen_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign retire_cnt   = cnt_q;
  assign err_unexp_wb = err_q;
endmodule
